// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester round-robin arbiter.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Burst counter width; a single-beat burst still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux2_datapath.sv
// Combinational 2-to-1 data mux driven by the arbiter's registered select.
module mux2_datapath #(
  parameter int DATA_W = 2
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter with bounded burst lock in front of a shared 2:1 mux.
// Define MUX2_ARB_STATS_EN to add saturating per-side grant counters.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int DATA_W    = 2,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              ready_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              ready_b,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              sel,
  output logic              busy
`ifdef MUX2_ARB_STATS_EN
  ,
  output logic [15:0]       gnt_cnt_a,
  output logic [15:0]       gnt_cnt_b
`endif
);

  localparam int            CW       = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          sel_q;

  logic       gnt_a, gnt_b, beat;
  logic       own_req, oth_req, oth_sel;
  arb_state_t oth_state;

  assign gnt_a     = (state_q == GNT_A);
  assign gnt_b     = (state_q == GNT_B);
  assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);
  assign ready_a   = gnt_a & out_ready;
  assign ready_b   = gnt_b & out_ready;
  assign beat      = out_valid & out_ready;
  assign busy      = (state_q != IDLE);
  assign sel       = sel_q;

  // View of the current grant as "own" vs "other" so both grant states share one rule set.
  assign own_req   = gnt_b ? req_b : req_a;
  assign oth_req   = gnt_b ? req_a : req_b;
  assign oth_sel   = gnt_b ? SEL_A : SEL_B;
  assign oth_state = gnt_b ? GNT_A : GNT_B;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req_a && (!req_b || last_q == SEL_B)) begin
          state_d = GNT_A;
          last_d  = SEL_A;
          cnt_d   = '0;
        end else if (req_b) begin
          state_d = GNT_B;
          last_d  = SEL_B;
          cnt_d   = '0;
        end
      end
      GNT_A, GNT_B: begin
        if (!own_req) begin
          if (oth_req) begin
            state_d = oth_state;
            last_d  = oth_sel;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (beat) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (oth_req) begin
              state_d = oth_state;
              last_d  = oth_sel;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= SEL_B;
      sel_q   <= SEL_A;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      // Select follows the grant and is left untouched while idle.
      if (state_d == GNT_A)      sel_q <= SEL_A;
      else if (state_d == GNT_B) sel_q <= SEL_B;
    end
  end

  mux2_datapath #(.DATA_W(DATA_W)) u_dp (
    .sel (sel_q),
    .a   (data_a),
    .b   (data_b),
    .y   (out_data)
  );

`ifdef MUX2_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gnt_cnt_a <= '0;
      gnt_cnt_b <= '0;
    end else begin
      if (state_d == GNT_A && state_q != GNT_A && gnt_cnt_a != 16'hFFFF)
        gnt_cnt_a <= gnt_cnt_a + 16'd1;
      if (state_d == GNT_B && state_q != GNT_B && gnt_cnt_b != 16'hFFFF)
        gnt_cnt_b <= gnt_cnt_b + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed vector table for the default arbiter plus a single-beat-burst alternation sequence.
module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration (MAX_BURST=4)
  logic       reset_n, req_a, req_b, out_ready;
  logic [1:0] data_a, data_b;
  logic       ready_a, ready_b, out_valid, sel, busy;
  logic [1:0] out_data;

  mux2_rr_arbiter #(.DATA_W(2), .MAX_BURST(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_a     (req_a),
    .data_a    (data_a),
    .ready_a   (ready_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .ready_b   (ready_b),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  // Single-beat bursts (MAX_BURST=1)
  logic       m_reset_n, m_req_a, m_req_b, m_out_ready;
  logic [1:0] m_data_a, m_data_b;
  logic       m_ready_a, m_ready_b, m_out_valid, m_sel, m_busy;
  logic [1:0] m_out_data;

  mux2_rr_arbiter #(.DATA_W(2), .MAX_BURST(1)) dut1 (
    .clk       (clk),
    .reset_n   (m_reset_n),
    .req_a     (m_req_a),
    .data_a    (m_data_a),
    .ready_a   (m_ready_a),
    .req_b     (m_req_b),
    .data_b    (m_data_b),
    .ready_b   (m_ready_b),
    .out_valid (m_out_valid),
    .out_data  (m_out_data),
    .out_ready (m_out_ready),
    .sel       (m_sel),
    .busy      (m_busy)
  );

  // exp = {out_valid, sel, busy, ready_a, ready_b, out_data[1:0]}
  typedef struct {
    logic       rst_n;
    logic       ra;
    logic       rb;
    logic [1:0] da;
    logic [1:0] db;
    logic       ordy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic v(input logic rst_n, input logic ra, input logic rb,
                   input logic [1:0] da, input logic [1:0] db,
                   input logic ordy, input logic [6:0] exp, input int reps);
    vec_t t;
    t.rst_n = rst_n; t.ra = ra; t.rb = rb; t.da = da; t.db = db;
    t.ordy = ordy; t.exp = exp;
    for (int r = 0; r < reps; r++) vecs.push_back(t);
  endtask

  initial begin
    logic [6:0] act;
    logic       exp_sel;
    logic [1:0] exp_d;

    // rst ra rb da     db     ordy  {ov,sel,busy,rA,rB,od}
    v(0, 1, 1, 2'b01, 2'b11, 1, 7'b0000001, 2);  // reset held, both requesting
    v(1, 1, 1, 2'b01, 2'b11, 1, 7'b0000001, 1);  // idle after release -> GNT_A
    v(1, 1, 0, 2'b10, 2'b11, 1, 7'b1011010, 6);  // lone A keeps grant past burst
    v(1, 1, 1, 2'b01, 2'b11, 0, 7'b1010001, 5);  // stall, cnt frozen at 2
    v(1, 1, 1, 2'b01, 2'b11, 1, 7'b1011001, 2);  // last two A beats of burst
    v(1, 1, 1, 2'b01, 2'b11, 1, 7'b1110111, 4);  // B burst
    v(1, 1, 1, 2'b01, 2'b11, 1, 7'b1011001, 4);  // A burst
    v(1, 1, 1, 2'b01, 2'b11, 1, 7'b1110111, 1);  // B beat, cnt 1
    v(1, 1, 0, 2'b01, 2'b11, 1, 7'b0110111, 1);  // B drops -> GNT_A
    v(1, 1, 1, 2'b01, 2'b11, 1, 7'b1011001, 1);  // A beat, cnt 1
    v(1, 0, 1, 2'b01, 2'b11, 1, 7'b0011001, 1);  // early release -> GNT_B
    v(1, 1, 1, 2'b01, 2'b11, 1, 7'b1110111, 2);  // B bursts, cnt reaches 2
    v(0, 1, 1, 2'b01, 2'b11, 1, 7'b1110111, 1);  // reset mid-burst
    v(1, 1, 1, 2'b01, 2'b11, 1, 7'b0000001, 1);  // idle, A wins first
    v(1, 1, 1, 2'b01, 2'b11, 1, 7'b1011001, 1);  // GNT_A
    v(1, 0, 0, 2'b01, 2'b11, 1, 7'b0011001, 1);  // nobody -> IDLE
    v(1, 0, 0, 2'b10, 2'b01, 1, 7'b0000010, 1);  // idle, sel holds 0
    v(1, 0, 1, 2'b10, 2'b01, 1, 7'b0000010, 1);  // only B -> GNT_B
    v(1, 0, 1, 2'b10, 2'b01, 1, 7'b1110101, 1);  // B beat
    v(1, 0, 0, 2'b10, 2'b01, 1, 7'b0110101, 1);  // nobody -> IDLE
    v(1, 0, 0, 2'b11, 2'b00, 1, 7'b0100000, 1);  // idle, sel holds 1
    v(1, 1, 1, 2'b01, 2'b11, 1, 7'b0100011, 1);  // both, last B -> GNT_A
    v(1, 1, 0, 2'b01, 2'b11, 1, 7'b1011001, 1);  // A beat
    v(1, 0, 0, 2'b01, 2'b11, 1, 7'b0011001, 1);  // -> IDLE, last A
    v(1, 1, 1, 2'b01, 2'b11, 1, 7'b0000001, 1);  // both, last A -> GNT_B
    v(1, 1, 1, 2'b01, 2'b11, 1, 7'b1110111, 1);  // GNT_B

    m_reset_n = 0; m_req_a = 0; m_req_b = 0; m_out_ready = 0;
    m_data_a = 2'b01; m_data_b = 2'b11;

    reset_n = 0; req_a = 1; req_b = 1; data_a = 2'b01; data_b = 2'b11; out_ready = 1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      reset_n = vecs[i].rst_n; req_a = vecs[i].ra; req_b = vecs[i].rb;
      data_a = vecs[i].da; data_b = vecs[i].db; out_ready = vecs[i].ordy;
      #2;
      act = {out_valid, sel, busy, ready_a, ready_b, out_data};
      checks++;
      if (act !== vecs[i].exp) begin
        errors++;
        $display("FAIL vec%0d {ov,sel,busy,rdya,rdyb,od}: got %b expected %b",
                 i, act, vecs[i].exp);
      end
      @(posedge clk); #1;
    end

    // MAX_BURST=1: strict single-beat alternation under contention
    m_req_a = 1; m_req_b = 1; m_out_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_reset_n = 1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      exp_sel = (k % 2 == 1);
      exp_d   = exp_sel ? 2'b11 : 2'b01;
      checks++;
      if (m_sel !== exp_sel || m_out_valid !== 1'b1 || m_out_data !== exp_d ||
          m_ready_a !== !exp_sel || m_ready_b !== exp_sel) begin
        errors++;
        $display("FAIL burst1 beat%0d: sel=%b ov=%b od=%b rdya=%b rdyb=%b expected sel=%b ov=1 od=%b",
                 k, m_sel, m_out_valid, m_out_data, m_ready_a, m_ready_b, exp_sel, exp_d);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
